// File: rtl/m_imem_loader_pkg.sv
// Shared constants for the UART imem boot loader:
// loader/RX state encodings and default timing.
package m_imem_loader_pkg;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int ADDR_W_DEF       = 12;

    localparam logic [2:0] S_HDR0 = 3'd0;
    localparam logic [2:0] S_HDR1 = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/m_imem_loader_if.sv
// imem write-port bundle driven by the boot loader.
// master = loader, slave = instruction memory.
interface m_imem_loader_if
    import m_imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_din;

    modport master (output r_addr, r_we, r_din);
    modport slave  (input  r_addr, r_we, r_din);
endinterface

// File: rtl/m_imem_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop sync, mid-bit sampling,
// glitch rejection on the start bit, framing error on a low stop bit.
module m_uart_rx
    import m_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       w_clk,
    input  logic       w_rst_n,
    input  logic       w_rxd,
    output logic [7:0] r_byte,
    output logic       r_valid,
    output logic       r_ferr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          rxd_s;

    assign rxd_s = sync_q[1];

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (st_q)
            RX_IDLE: begin
                if (prev_q && !rxd_s) begin
                    st_d  = RX_START;
                    cnt_d = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // line back high at mid-start means it was a glitch
                    st_d  = rxd_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    sh_d  = {rxd_s, sh_q[7:1]};
                    if (bit_q == 3'd7) st_d = RX_STOP;
                    else               bit_d = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    st_d    = RX_IDLE;
                    valid_d = rxd_s;
                    ferr_d  = !rxd_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], w_rxd};
            prev_q  <= rxd_s;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign r_byte  = sh_q;
    assign r_valid = valid_q;
    assign r_ferr  = ferr_q;

endmodule

// File: rtl/m_imem_loader.sv
// UART boot loader: writes a word-count-prefixed image into imem and
// releases processor reset on success. Optional: IMEM_LOADER_CHECKSUM_EN.
module m_imem_loader
    import m_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input  logic            w_clk,
    input  logic            w_rst_n,
    input  logic            w_rxd,
    m_imem_loader_if.master imem,
    output logic            r_proc_rst,
    output logic            r_done,
    output logic            r_err
);
    localparam logic [16:0] NMAX = 17'(2 ** ADDR_W);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_AFTER = S_CSUM;
    logic [7:0] csum_q, csum_d;
`else
    localparam logic [2:0] S_AFTER = S_DONE;
`endif

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_ferr;
    logic [2:0]        st_q, st_d;
    logic [7:0]        nhi_q, nhi_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       din_q, din_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              prst_q, prst_d;
    logic [15:0]       n16;
    logic              term;

    m_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .w_clk  (w_clk),
        .w_rst_n(w_rst_n),
        .w_rxd  (w_rxd),
        .r_byte (rx_byte),
        .r_valid(rx_valid),
        .r_ferr (rx_ferr)
    );

    assign n16  = {nhi_q, rx_byte};
    assign term = (st_q == S_DONE) || (st_q == S_ERR);

    always_comb begin
        st_d   = st_q;
        nhi_d  = nhi_q;
        n_d    = n_q;
        wcnt_d = wcnt_q;
        word_d = word_q;
        bcnt_d = bcnt_q;
        addr_d = addr_q;
        we_d   = 1'b0;
        din_d  = din_q;
        done_d = done_q;
        err_d  = err_q;
        prst_d = prst_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = csum_q;
`endif
        // cycle after a write: advance, or finish without wrapping addr
        if (we_q) begin
            wcnt_d = wcnt_q + 16'd1;
            if (wcnt_q + 16'd1 == n_q) st_d = S_AFTER;
            else                       addr_d = addr_q + 1'b1;
        end
        if (rx_ferr && !term) begin
            st_d = S_ERR;
        end else if (rx_valid) begin
            case (st_q)
                S_HDR0: begin
                    nhi_d = rx_byte;
                    st_d  = S_HDR1;
                end
                S_HDR1: begin
                    n_d    = n16;
                    wcnt_d = '0;
                    bcnt_d = '0;
                    addr_d = '0;
                    if (n16 == 16'd0)             st_d = S_AFTER;
                    else if ({1'b0, n16} > NMAX) st_d = S_ERR;
                    else                          st_d = S_DATA;
                end
                S_DATA: begin
                    word_d = {word_q[23:0], rx_byte};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q + rx_byte;
`endif
                    if (bcnt_q == 2'd3) begin
                        we_d  = 1'b1;
                        din_d = {word_q[23:0], rx_byte};
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    st_d = (rx_byte == csum_q) ? S_DONE : S_ERR;
                end
`endif
                default: ;
            endcase
        end
        if (st_d == S_DONE) begin
            done_d = 1'b1;
            prst_d = 1'b0;
        end
        if (st_d == S_ERR) err_d = 1'b1;
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            st_q   <= S_HDR0;
            nhi_q  <= '0;
            n_q    <= '0;
            wcnt_q <= '0;
            word_q <= '0;
            bcnt_q <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            din_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            prst_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            st_q   <= st_d;
            nhi_q  <= nhi_d;
            n_q    <= n_d;
            wcnt_q <= wcnt_d;
            word_q <= word_d;
            bcnt_q <= bcnt_d;
            addr_q <= addr_d;
            we_q   <= we_d;
            din_q  <= din_d;
            done_q <= done_d;
            err_q  <= err_d;
            prst_q <= prst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

    assign imem.r_addr = addr_q;
    assign imem.r_we   = we_q;
    assign imem.r_din  = din_q;
    assign r_proc_rst  = prst_q;
    assign r_done      = done_q;
    assign r_err       = err_q;

endmodule
